// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY constants: 128b/130b sync headers and the SKP ordered-set payload.
package pcie_phy_pkg;

    typedef logic [1:0] sync_hdr_t;

    localparam sync_hdr_t SYNC_DATA = 2'b10;
    localparam sync_hdr_t SYNC_OS   = 2'b01;

    localparam logic [7:0] SKP_BYTE = 8'hAA;
    localparam logic [7:0] SKP_END  = 8'hE1;
    localparam int unsigned SKP_END_IDX = 12;

    // Byte 0 sits at bits [7:0]; bytes beyond the SKP_END symbol stay zero.
    function automatic logic [127:0] skp_payload(int unsigned width);
        logic [127:0] p;
        p = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i * 8 < width) begin
                if (i < SKP_END_IDX)
                    p[i*8 +: 8] = SKP_BYTE;
                else if (i == SKP_END_IDX)
                    p[i*8 +: 8] = SKP_END;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/pcie_tx_block_encoder_if.sv
// Block stream bus of the TX block encoder: upstream block input, SKP controls, 130b output.
interface pcie_tx_block_encoder_if #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned BLOCK_WIDTH = 128
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic                                   in_is_os;
    logic [NUM_LANES*BLOCK_WIDTH-1:0]       in_data;
    logic                                   skp_enable;
    logic                                   force_skp;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [NUM_LANES*(BLOCK_WIDTH+2)-1:0]   out_data;
    logic                                   out_is_skp;

    modport master (
        output in_valid, in_is_os, in_data, skp_enable, force_skp, out_ready,
        input  in_ready, out_valid, out_data, out_is_skp
    );

    modport slave (
        input  in_valid, in_is_os, in_data, skp_enable, force_skp, out_ready,
        output in_ready, out_valid, out_data, out_is_skp
    );
endinterface

// File: rtl/pcie_skp_scheduler.sv
// SKP scheduling: counts accepted data blocks, latches forced requests, gates upstream ready.
module pcie_skp_scheduler #(
    parameter int unsigned SKP_INTERVAL = 370
) (
    input  logic clk,
    input  logic reset,
    input  logic skp_enable,
    input  logic force_skp,
    input  logic load,
    input  logic in_valid,
    input  logic in_is_os,
    output logic in_ready,
    output logic insert
);
    localparam int unsigned CW = $clog2(SKP_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SKP_INTERVAL);

    logic [CW-1:0] cnt;
    logic          skp_pending;
    logic          skp_due;
    logic          accept_data;

    always_comb begin
        skp_due     = skp_enable && (cnt == CNT_MAX);
        insert      = (skp_due || skp_pending) && load;
        in_ready    = load && !(skp_due || skp_pending) && !reset;
        accept_data = in_valid && in_ready && !in_is_os;
    end

    // A force arriving in the cycle of an insert is absorbed by that insert.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else if (insert) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else begin
            if (accept_data && (cnt != CNT_MAX))
                cnt <= cnt + 1'b1;
            if (force_skp)
                skp_pending <= 1'b1;
        end
    end
endmodule

// File: rtl/pcie_tx_block_encoder.sv
// Gen3+ 128b/130b TX block encoder: per-lane sync header, SKP insertion, registered output.
module pcie_tx_block_encoder
    import pcie_phy_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned BLOCK_WIDTH  = 128,
    parameter int unsigned SKP_INTERVAL = 370
) (
    input  logic                    clk,
    input  logic                    reset,
    pcie_tx_block_encoder_if.slave  bus
);
    localparam int unsigned LW = BLOCK_WIDTH + 2;
    localparam logic [BLOCK_WIDTH-1:0] SKP_LANE = BLOCK_WIDTH'(skp_payload(BLOCK_WIDTH));

    logic                  load;
    logic                  insert;
    logic                  in_ready;
    logic                  accept;
    sync_hdr_t             hdr;
    logic [NUM_LANES*LW-1:0] data_blk;
    logic [NUM_LANES*LW-1:0] skp_blk;
    logic                  out_valid_q;
    logic                  out_is_skp_q;
    logic [NUM_LANES*LW-1:0] out_data_q;

    pcie_skp_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_sched (
        .clk        (clk),
        .reset      (reset),
        .skp_enable (bus.skp_enable),
        .force_skp  (bus.force_skp),
        .load       (load),
        .in_valid   (bus.in_valid),
        .in_is_os   (bus.in_is_os),
        .in_ready   (in_ready),
        .insert     (insert)
    );

    always_comb begin
        load     = !out_valid_q || bus.out_ready;
        accept   = bus.in_valid && in_ready;
        hdr      = bus.in_is_os ? SYNC_OS : SYNC_DATA;
        data_blk = '0;
        skp_blk  = '0;
        for (int unsigned n = 0; n < NUM_LANES; n++) begin
            data_blk[n*LW +: LW] = {hdr, bus.in_data[n*BLOCK_WIDTH +: BLOCK_WIDTH]};
            skp_blk[n*LW +: LW]  = {SYNC_OS, SKP_LANE};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_is_skp_q <= 1'b0;
            out_data_q   <= '0;
        end else if (load) begin
            if (insert) begin
                out_valid_q  <= 1'b1;
                out_is_skp_q <= 1'b1;
                out_data_q   <= skp_blk;
            end else if (accept) begin
                out_valid_q  <= 1'b1;
                out_is_skp_q <= 1'b0;
                out_data_q   <= data_blk;
            end else begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.in_ready   = in_ready;
        bus.out_valid  = out_valid_q;
        bus.out_is_skp = out_is_skp_q;
        bus.out_data   = out_data_q;
    end
endmodule

// File: tb/tb_pcie_tx_block_encoder.sv
// Directed plus randomized checks of the TX block encoder against a cycle-level reference model.
module tb_pcie_tx_block_encoder;
    localparam int unsigned NL = 2;
    localparam int unsigned BW = 128;
    localparam int unsigned SI = 4;
    localparam int unsigned LW = BW + 2;
    localparam int unsigned OW = NL * LW;
    localparam logic [BW-1:0] SKP_REF = {8'h00, 8'h00, 8'h00, 8'hE1, {12{8'hAA}}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pcie_tx_block_encoder_if #(.NUM_LANES(NL), .BLOCK_WIDTH(BW)) bus ();

    pcie_tx_block_encoder #(
        .NUM_LANES    (NL),
        .BLOCK_WIDTH  (BW),
        .SKP_INTERVAL (SI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_skp = 0;

    // Reference model state: expected output register contents plus SKP bookkeeping.
    int            m_cnt;
    bit            m_pend;
    logic          m_valid;
    logic          m_skp;
    logic [OW-1:0] m_data;

    function automatic logic [OW-1:0] build(bit os, logic [NL*BW-1:0] d, bit skp);
        logic [OW-1:0] r;
        for (int l = 0; l < NL; l++)
            r[l*LW +: LW] = skp ? {2'b01, SKP_REF} : {(os ? 2'b01 : 2'b10), d[l*BW +: BW]};
        return r;
    endfunction

    task automatic chk(string tag, logic [OW-1:0] got, logic [OW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_valid = 0; m_skp = 0; m_data = '0;
    endtask

    // Check the current cycle, advance the model by one clock, then step the DUT.
    task automatic tick();
        bit ld, busy, er;
        @(negedge clk);
        ld   = !m_valid || bus.out_ready;
        busy = (bus.skp_enable && m_cnt == SI) || m_pend;
        er   = ld && !busy && !reset;
        chk("in_ready",   OW'(bus.in_ready),   OW'(er));
        chk("out_valid",  OW'(bus.out_valid),  OW'(m_valid));
        chk("out_is_skp", OW'(bus.out_is_skp), OW'(m_skp));
        chk("out_data",   bus.out_data,        m_data);
        if (reset) begin
            model_reset();
        end else if (ld && busy) begin
            m_valid = 1; m_skp = 1; m_data = build(0, '0, 1);
            m_cnt = 0; m_pend = 0; n_skp++;
        end else begin
            if (bus.in_valid && er) begin
                m_valid = 1; m_skp = 0; m_data = build(bus.in_is_os, bus.in_data, 0);
                if (!bus.in_is_os && m_cnt < SI) m_cnt++;
            end else if (ld) begin
                m_valid = 0;
            end
            if (bus.force_skp) m_pend = 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*BW-1:0] rand_data();
        logic [NL*BW-1:0] d;
        for (int i = 0; i < int'(NL * BW / 32); i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        int skp_before;
        reset = 1;
        bus.in_valid = 0; bus.in_is_os = 0; bus.in_data = '0;
        bus.skp_enable = 0; bus.force_skp = 0; bus.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        reset = 0;

        // Directed data then OS beat
        bus.in_valid = 1;
        bus.in_data = {{32{4'h5}}, 128'h0123456789ABCDEF0123456789ABCDEF};
        tick();
        bus.in_is_os = 1;
        bus.in_data = {2{{32{4'h1}} ^ {16{8'h0F}}}};
        tick();
        bus.in_valid = 0; bus.in_is_os = 0;
        tick();

        // Continuous data with scheduled SKP
        bus.skp_enable = 1;
        skp_before = n_skp;
        bus.in_valid = 1;
        for (int i = 0; i < 14; i++) begin
            bus.in_data = rand_data();
            tick();
        end
        chk("sched_skp_count", OW'(n_skp - skp_before >= 2), OW'(1));

        // Stall for three cycles
        bus.out_ready = 0;
        repeat (3) tick();
        bus.out_ready = 1;
        repeat (2) tick();

        // Force in the cycle cnt reaches the interval
        for (int i = 0; i < 20 && m_cnt != SI - 1; i++) begin
            bus.in_data = rand_data();
            tick();
        end
        skp_before = n_skp;
        bus.force_skp = 1;
        tick();
        bus.force_skp = 0;
        repeat (SI + 1) tick();
        chk("force_due_single_skp", OW'(n_skp - skp_before), OW'(1));

        // Force during a stall
        bus.out_ready = 0;
        tick();
        skp_before = n_skp;
        bus.force_skp = 1;
        tick();
        bus.force_skp = 0;
        tick();
        bus.out_ready = 1;
        repeat (2) tick();
        chk("force_stall_skp", OW'(n_skp - skp_before), OW'(1));

        // Reset during stall with pending SKP
        bus.skp_enable = 0;
        bus.out_ready = 0;
        bus.force_skp = 1;
        tick();
        bus.force_skp = 0;
        reset = 1;
        tick();
        reset = 0;
        bus.out_ready = 1;
        skp_before = n_skp;
        repeat (3) tick();
        chk("no_skp_after_reset", OW'(n_skp - skp_before), OW'(0));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_is_os   = ($urandom_range(0, 7) == 0);
            bus.in_data    = rand_data();
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.skp_enable = ($urandom_range(0, 9) != 0);
            bus.force_skp  = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pcie_tx_block_encoder.md
Name: pcie_tx_block_encoder

Overview:
- Gen3+ TX 128b/130b block encoder for the PHY TX path.
- Accepts one 128-bit block per lane per beat, tags the block type, prepends the correct 2-bit sync header per lane and emits 130-bit blocks through a registered valid/ready stage.
- Schedules SKP ordered-set insertion on all lanes every SKP_INTERVAL data blocks, or on request, and back-pressures upstream while inserting.
- Sits between the TX framing/scrambler stage and the serializer/gearbox.

Parameters:
- NUM_LANES, 4, number of lanes encoded in lockstep (1..16).
- BLOCK_WIDTH, 128, payload bits per lane per block.
- SKP_INTERVAL, 370, data blocks between scheduled SKP blocks (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream block valid.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_is_os  input  1  0 = data block, 1 = ordered-set block (applies to all lanes).
- in_data  input  NUM_LANES*BLOCK_WIDTH  lane n payload at [n*BLOCK_WIDTH +: BLOCK_WIDTH].
- skp_enable  input  1  enables scheduled SKP insertion.
- force_skp  input  1  single-cycle request for one SKP block at the next opportunity.
- out_valid  output  1  output block valid.
- out_ready  input  1  downstream accept.
- out_data  output  NUM_LANES*(BLOCK_WIDTH+2)  lane n at [n*(BLOCK_WIDTH+2) +: BLOCK_WIDTH+2] = {sync_hdr[1:0], payload}.
- out_is_skp  output  1  current output block is an inserted SKP.

Behaviour:
- Reset (synchronous, active-high, applies on the next clk edge): out_valid=0, out_data=0, out_is_skp=0, data counter=0, skp_pending=0. in_ready is 0 while reset is high.
- Sync header per lane: data block = SYNC_DATA (2'b10); ordered set or SKP = SYNC_OS (2'b01). All lanes carry the same header in a beat.
- Output stage is one register. load = !out_valid || out_ready.
- Latency: an accepted block appears on out_data the cycle after acceptance.
- Stall: while out_valid && !out_ready, out_data, out_valid and out_is_skp hold stable.
- skp_due = skp_enable && (cnt == SKP_INTERVAL). insert = (skp_due || skp_pending) && load.
- in_ready = load && !(skp_due || skp_pending). in_ready is combinational from out_ready; there is no combinational path from in_valid.
- On insert:
  - Output register loads the SKP block on every lane: {SYNC_OS, SKP_PAYLOAD}, with out_is_skp=1.
  - cnt<=0 and skp_pending<=0.
  - Upstream is stalled that cycle.
- SKP_PAYLOAD byte order, byte 0 at bits [7:0]: bytes 0-11 = 8'hAA, byte 12 = 8'hE1, bytes 13-15 = 8'h00.
- On accepted data block: cnt <= cnt+1, saturating at SKP_INTERVAL. Accepted OS blocks do not change cnt.
- skp_enable=0: cnt still counts and saturates; no scheduled insertion occurs. Re-enabling with cnt saturated inserts SKP at the next load opportunity.
- force_skp: sets skp_pending (sticky) on the cycle it is high, unless an insert happens in that same cycle. Force and due together, or force during an insert, produce exactly one SKP.
- No load and no input: out_valid <= 0 once the current block is taken.
- Upstream owns EDS/stream-state rules; this block does not check them.
- Widths: cnt is $clog2(SKP_INTERVAL+1) bits; no wrap.

Decomposition:
- Package pcie_phy_pkg holds:
  - SYNC_DATA and SYNC_OS (2-bit constants).
  - SKP_BYTE=8'hAA, SKP_END=8'hE1.
  - Function skp_payload(width) returning the 128-bit SKP payload.
  - Typedef sync_hdr_t (logic [1:0]).
- One sub-module is natural: pcie_skp_scheduler, containing cnt, skp_pending, skp_due/insert and the in_ready gating. The top level holds the per-lane header mux and the output register.

Test Plan:
- Reset, then NUM_LANES=2, out_ready=1, one data beat with lane0=128'h0123...EF, lane1=all 5s → next cycle out_valid=1; lane0 bits[129:128]=2'b10 with payload 0123...EF; lane1=2'b10 with all 5s; out_is_skp=0.
- OS beat (in_is_os=1, payload 128'h1E...) → both lanes carry header 2'b01 and the unchanged payload.
- SKP_INTERVAL=4, skp_enable=1, continuous data → after the 4th accepted data block, in_ready=0 for one cycle; next output is SKP (bytes AA×12, E1, 00×3, header 01, out_is_skp=1); counting restarts and the next SKP follows 4 data blocks later.
- out_ready held low 3 cycles with out_valid=1 → out_data stable, in_ready=0, no block lost or duplicated after release.
- force_skp pulsed in the same cycle cnt reaches SKP_INTERVAL → exactly one SKP emitted, skp_pending=0 afterwards; force_skp during a stall → SKP emitted once out_ready returns.
- reset asserted during a stall with a pending SKP → next cycle out_valid=0, in_ready=0; after deassertion the first data block passes with no SKP inserted.
